// File: rtl/conv2_window_buf.sv
// conv2_window_buf: raster-order 8-channel binary pixels -> 3x3x8 sliding windows for conv2.
// Latency 1 cycle (registered window/valid); no backpressure, one pixel per cycle.
// Optional CONV2_BUF_FRAME_DONE_EN adds frame_done, pulsed with the last window of each frame.
module conv2_window_buf #(
    parameter int IMG_W = 13,
    parameter int IMG_H = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [7:0]  pixel_in,
    output logic [71:0] pixel_windows,
    output logic        valid_in_buf
`ifdef CONV2_BUF_FRAME_DONE_EN
    ,
    output logic        frame_done
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    lb_old_q [IMG_W];
    logic [7:0]    lb_new_q [IMG_W];
    logic [7:0]    win_q [3][3];
    logic [7:0]    win_d [3][3];
    logic [71:0]   pw_q, pw_d;
    logic          vld_q, vld_d;
    logic          win_ok;
    logic          last_px;
    logic          fd_q, fd_d;

    assign win_ok  = valid_in && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_px = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        vld_d = win_ok;
        fd_d  = win_ok && last_px;
        pw_d  = '0;
        if (valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_old_q[col_q];
            win_d[1][2] = lb_new_q[col_q];
            win_d[2][2] = pixel_in;
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        // Output is forced to zero unless a full in-frame window is being emitted.
        if (win_ok) begin
            for (int ch = 0; ch < 8; ch++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        pw_d[ch*9 + r*3 + c] = win_d[r][c][ch];
        end
    end

    // Line buffers are not reset: a window needs row>=2, so stale data never escapes.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb_old_q[col_q] <= lb_new_q[col_q];
            lb_new_q[col_q] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            vld_q <= 1'b0;
            pw_q  <= '0;
            fd_q  <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            vld_q <= vld_d;
            pw_q  <= pw_d;
            fd_q  <= fd_d;
            win_q <= win_d;
        end
    end

    assign pixel_windows = pw_q;
    assign valid_in_buf  = vld_q;

`ifdef CONV2_BUF_FRAME_DONE_EN
    assign frame_done = fd_q;
`else
    logic unused_fd;
    assign unused_fd = fd_q;
`endif

endmodule

// File: doc/conv2_window_buf.md
CONV2_WINDOW_BUF -- requirements
Module: conv2_window_buf

Interface
REQ-001 SHALL have parameter IMG_W, default 13, meaning input feature-map width in pixels (minimum 3).
REQ-002 SHALL have parameter IMG_H, default 13, meaning input feature-map height in pixels (minimum 3).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port valid_in, input, 1 bit: pixel_in is valid this cycle.
REQ-006 SHALL have port pixel_in, input, 8 bits: one binary pixel for all 8 conv1 channels; bit ch is channel ch; pixels arrive in raster order.
REQ-007 SHALL have port pixel_windows, output, 72 bits: the 3x3x8 binary window for the conv2 calculator.
REQ-008 SHALL have port valid_in_buf, output, 1 bit: pixel_windows is valid this cycle.

Function
REQ-009 SHALL keep two line buffers of IMG_W x 8 bits holding the previous two rows, plus a 3x3x8 window shift register.
REQ-010 SHALL keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1); each accepted pixel (valid_in=1) advances col; col wraps from IMG_W-1 to 0 and advances row; row wraps from IMG_H-1 to 0, which starts a new frame.
REQ-011 SHALL, on each accepted pixel, shift the window left by one column and load the new right column as {row-2 pixel, row-1 pixel, pixel_in} at column col, then write pixel_in into the line buffers in place of the oldest row at col.
REQ-012 SHALL pack pixel_windows[ch*9 + r*3 + c] = channel ch at window row r (0 = top/oldest) and column c (0 = left/oldest).
REQ-013 SHALL assert valid_in_buf for exactly one cycle, the cycle after accepting a pixel with row>=2 and col>=2; this is a registered, 1-cycle latency.
REQ-014 SHALL emit exactly (IMG_W-2)*(IMG_H-2) windows per frame (121 at default); no window SHALL span a row wrap.
REQ-015 SHALL drive pixel_windows to all zeros whenever valid_in_buf=0.
REQ-016 SHALL hold all counters, buffers and the window when valid_in=0; gaps of any length between pixels SHALL NOT change the output sequence.
REQ-017 SHALL accept back-to-back pixels at one per cycle with no backpressure; the downstream calculator is combinational and always ready.
REQ-018 SHALL process the first pixel of a new frame without any idle cycle; stale line-buffer contents SHALL NOT produce a valid window, because valid requires row>=2.

Reset
REQ-019 SHALL, while rst_n=0, immediately clear col, row, valid_in_buf and pixel_windows to 0, independent of clk.
REQ-020 SHALL NOT require line-buffer contents to be cleared by reset.
REQ-021 SHALL treat reset asserted mid-frame as a frame abort: the first accepted pixel after release is row 0, col 0.

Configuration
REQ-022 SHALL, when macro CONV2_BUF_FRAME_DONE_EN is defined, add output frame_done (1 bit, reset 0), pulsed for one cycle coincident with the last valid_in_buf of each frame.
REQ-023 SHALL, when CONV2_BUF_FRAME_DONE_EN is undefined, have no frame_done port, with all other behaviour identical.

Verification
REQ-024 Default parameters, 169 back-to-back pixels -> exactly 121 valid_in_buf pulses; the first pulse comes 1 cycle after pixel index 28 (row 2, col 2).
REQ-025 Frame with pixel_in = 8'hFF at (row 1, col 1) only, else 0 -> the first window has pixel_windows = bit 4 set in every channel slice (72'h...: bits ch*9+4 =1), all other bits 0.
REQ-026 Same 169-pixel frame with random 0-5 cycle valid_in gaps -> window sequence and count identical to REQ-024.
REQ-027 Assert rst_n=0 after 50 pixels, release, send a full frame -> 121 windows, all matching a reference model started at pixel 0; valid_in_buf=0 and pixel_windows=0 during reset.
REQ-028 Two consecutive frames back-to-back -> 242 windows total, none emitted for rows 0-1 of frame 2; with CONV2_BUF_FRAME_DONE_EN defined, frame_done pulses exactly twice, aligned to windows 121 and 242.
